// File: rtl/uart_pkg.sv
// Shared types and constants for the host UART result return path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [7:0]  UART_SYNC_BYTE  = 8'hA5;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. It can take the next byte in the last stop-bit cycle,
// so consecutive frames have no idle gap between them.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx,
    output tx_state_t  state
);

    localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_end;

    assign bit_end    = (baud_cnt == BaudMax);
    assign byte_ready = (state == IDLE) || ((state == STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= ((state == IDLE) || bit_end) ? '0 : baud_cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    if (byte_valid) begin
                        shift <= byte_data;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        shift <= shift >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx      <= 1'b1;
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        // Chain straight into the next start bit when another byte waits.
                        if (byte_valid) begin
                            shift <= byte_data;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Sends each accepted label to the host as SYNC_BYTE + label (8N1 frames).
// Define UART_RESULT_TX_CHECKSUM_EN to append a third byte, SYNC_BYTE ^ label.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = UART_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_valid,
    input  logic [7:0] result,
    output logic       result_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef UART_RESULT_TX_CHECKSUM_EN
    localparam logic [1:0] LastByte = 2'd2;
`else
    localparam logic [1:0] LastByte = 2'd1;
`endif

    tx_state_t  state;
    logic [1:0] byte_idx;
    logic [1:0] next_idx;
    logic [7:0] label;
    logic [7:0] byte_data;
    logic       accept;
    logic       more_bytes;
    logic       byte_valid;
    logic       byte_ready;
    logic       last_stop;

    assign result_ready = (state == IDLE) && !rst;
    assign accept       = result_valid && result_ready;
    assign more_bytes   = (state == STOP) && (byte_idx != LastByte);
    assign byte_valid   = accept || more_bytes;
    assign next_idx     = byte_idx + 2'd1;
    assign last_stop    = (state == STOP) && byte_ready;

    always_comb begin
        byte_data = SYNC_BYTE;
        if (!accept) begin
            case (next_idx)
                2'd1:    byte_data = label;
`ifdef UART_RESULT_TX_CHECKSUM_EN
                2'd2:    byte_data = SYNC_BYTE ^ label;
`endif
                default: byte_data = SYNC_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            label    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_stop && !more_bytes;
            if (accept) begin
                label    <= result;
                byte_idx <= '0;
                busy     <= 1'b1;
            end else if (last_stop) begin
                if (more_bytes) begin
                    byte_idx <= next_idx;
                end else begin
                    busy <= 1'b0;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx),
        .state      (state)
    );

endmodule
